cdc_a2s_rx_buffered: RTL
========================

Name: cdc_a2s_rx_buffered

Overview:
- Synthesizable synchronous-side receiver for an asynchronous-to-synchronous channel crossing.
- Accepts bundled-data tokens from a QDI/async sender over a request (Si) / acknowledge (So) pair.
- Synchronizes the request with an SYNC_STAGES flip-flop chain and stores each token in a parametrised FIFO.
- Presents tokens to synchronous logic on a first-word-fall-through valid/ready port.
- Generalises the earlier fixed-width, unbuffered, 4-phase-only receiver: adds selectable 2-phase/4-phase protocol, buffering with backpressure, and token/occupancy counters.

Parameters:
- DW, 64, data bus width in bits.
- DEPTH, 4, FIFO depth in words; power of two, >= 2.
- SYNC_STAGES, 2, request synchronizer length; >= 2.
- PHASES, 4, handshake protocol; 4 = return-to-zero, 2 = transition signalling.
- CW, 32, width of the rx_tokens counter.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- Si  input  1  async request from sender; asynchronous to CLK.
- Din  input  DW  bundled data; stable whenever the request indicates a pending token.
- So  output  1  acknowledge to sender; registered.
- dout  output  DW  FIFO head word.
- dout_valid  output  1  FIFO non-empty.
- dout_ready  input  1  consumer accepts the head word this cycle.
- level  output  $clog2(DEPTH)+1  FIFO occupancy.
- rx_tokens  output  CW  count of tokens accepted since reset; wraps modulo 2^CW.

Behaviour:
- Reset (RESET=1 at a CLK edge): sync chain=0, So=0, FIFO empty, level=0, dout_valid=0, rx_tokens=0, FSM=IDLE. dout is don't-care while dout_valid=0.
- si_s is the last stage of the synchronizer chain. Din is never synchronized; the bundled-data timing guarantee covers it.
- full: level==DEPTH, evaluated on the registered level. A pop in the same cycle does NOT enable a push; the push waits one cycle.
- 4-phase FSM:
  - IDLE: if si_s=1 and !full, push Din, rx_tokens+1, So<=1, go to ACK. If si_s=1 and full, hold, with So=0 (backpressure).
  - ACK: if si_s=0, So<=0, go to IDLE. Otherwise hold.
- 2-phase mode:
  - Token pending when si_s != So. If pending and !full: push Din, rx_tokens+1, So<=si_s.
  - Data is captured on each request transition, rising or falling.
- Latency:
  - Si edge to So edge is SYNC_STAGES+1 CLK cycles when not full.
  - Push to dout_valid=1 is 1 cycle (dout and dout_valid update on the edge after the push).
- Pop: on dout_valid & dout_ready, advance the read pointer. dout_ready with an empty FIFO has no effect.
- Simultaneous push and pop with the FIFO not full: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; level saturates at neither end, because push/pop gating prevents overflow and underflow.
- Reset mid-handshake: all state clears, So drops. A sender still holding Si=1 is then treated as a new token after synchronization. Sender and receiver resets must be coordinated at system level.
- No combinational path from any input to any output.

Decomposition:
- Shared package (cdc_pkg):
  - PHASES_2 and PHASES_4 constants.
  - Receive FSM state enum {IDLE, ACK}.
  - Default SYNC_STAGES constant.
- Sub-modules:
  - sync_ff_chain (parametrised, reset-to-0), reusable by the sync-to-async transmitter.
  - FIFO storage (data array, pointers, level) held inline.

Test Plan:
- 4-phase, DEPTH=4, dout_ready=1; send 16 tokens with Din=i → 16 words out in order, values 0..15; rx_tokens=16; Si-rise to So-rise exactly 3 cycles.
- 4-phase, dout_ready=0; send 5 tokens 0xA0..0xA4 → 4 acked, level=4; 5th request sees So held 0. Raise dout_ready for 1 cycle → 0xA0 popped, 5th acked one cycle after the pop, level returns to 4.
- 2-phase mode; toggle Si 8 times with Din=0x11*k → 8 words captured; So tracks Si after each toggle; rx_tokens=8.
- Simultaneous push and pop at level=2 → level stays 2, order preserved.
- Assert RESET while in ACK with Si=1 → So=0, level=0, rx_tokens=0 next cycle; token re-accepted SYNC_STAGES+1 cycles after reset release.
- Preload rx_tokens near wrap (CW=4, 17 tokens) → rx_tokens reads 1.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared constants and types for the async/sync channel crossing.
// Used by the receiver and the companion transmitter.
package cdc_pkg;

    localparam int PHASES_2 = 2;
    localparam int PHASES_4 = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE,
        ACK
    } rx_state_t;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single-bit asynchronous input.
// Clears to 0 on reset; q is the last stage.
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_a2s_rx_buffered.sv
// Synchronous-side receiver for bundled-data tokens from an async sender.
// Synchronizes the request, buffers tokens in a FIFO, presents them FWFT.
module cdc_a2s_rx_buffered
    import cdc_pkg::*;
#(
    parameter int DW          = 64,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int PHASES      = PHASES_4,
    parameter int CW          = 32,
    localparam int AW         = $clog2(DEPTH),
    localparam int LW         = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          Si,
    input  logic [DW-1:0] Din,
    output logic          So,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [LW-1:0] level,
    output logic [CW-1:0] rx_tokens
);

    logic          si_s;
    logic          full;
    logic          push;
    logic          pop;
    logic          so_nxt;
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [DW-1:0] mem [DEPTH];

    sync_ff_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .CLK  (CLK),
        .RESET(RESET),
        .d    (Si),
        .q    (si_s)
    );

    assign full       = (level == LW'(DEPTH));
    assign dout_valid = (level != '0);
    assign pop        = dout_valid & dout_ready;
    assign dout       = mem[rptr];

    // Handshake decode: decide push and next acknowledge level.
    always_comb begin
        state_nxt = state;
        so_nxt    = So;
        push      = 1'b0;
        if (PHASES == PHASES_2) begin
            if ((si_s != So) && !full) begin
                push   = 1'b1;
                so_nxt = si_s;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    so_nxt = 1'b0;
                    if (si_s && !full) begin
                        push      = 1'b1;
                        so_nxt    = 1'b1;
                        state_nxt = ACK;
                    end
                end
                ACK: begin
                    if (!si_s) begin
                        so_nxt    = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Handshake state, acknowledge and token counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            So        <= 1'b0;
            rx_tokens <= '0;
        end else begin
            state <= state_nxt;
            So    <= so_nxt;
            if (push) begin
                rx_tokens <= rx_tokens + CW'(1);
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since level gates validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= Din;
        end
    end

endmodule
